// File: rtl/param_sender_if.sv
// Parameter-load bus between the host-side sender and the Mandelbrot parameter receiver.
// The sender owns the master modport; the host/receiver side uses slave.
interface param_sender_if;
    logic        start;
    logic [35:0] corner_in;
    logic [9:0]  maxiter_in;
    logic [8:0]  res_in;
    logic [35:0] corner_d;
    logic [9:0]  maxiter_d;
    logic [8:0]  res_d;
    logic        write;
    logic        busy;
    logic        done;
    logic [2:0]  state_dbg;

    // start is a level request sampled only while the sender is idle; there is no
    // back-pressure. The bus (*_d) is stable whenever write is high, and a transfer
    // is complete only when done pulses.
    modport master (
        input  start, corner_in, maxiter_in, res_in,
        output corner_d, maxiter_d, res_d, write, busy, done, state_dbg
    );

    modport slave (
        output start, corner_in, maxiter_in, res_in,
        input  corner_d, maxiter_d, res_d, write, busy, done, state_dbg
    );
endinterface

// File: rtl/param_sender.sv
// Host-side transmitter: latches one parameter set, holds it on the bus and emits
// NUM_PULSES write pulses, then a tail so the receiver can load before done.
module param_sender #(
    parameter int PULSE_HIGH = 2,
    parameter int PULSE_LOW  = 2,
    parameter int NUM_PULSES = 5,
    parameter int TAIL_CYC   = 3
) (
    input  logic           clk,
    input  logic           rst,
    param_sender_if.master bus
);
    localparam int MAX_HL = (PULSE_HIGH > PULSE_LOW) ? PULSE_HIGH : PULSE_LOW;
    localparam int MAX_PH = (MAX_HL > TAIL_CYC) ? MAX_HL : TAIL_CYC;
    localparam int PH_W   = $clog2(MAX_PH + 1);
    localparam int PU_W   = $clog2(NUM_PULSES + 1);

    localparam logic [PH_W-1:0] HIGH_LAST  = PH_W'(PULSE_HIGH - 1);
    localparam logic [PH_W-1:0] LOW_LAST   = PH_W'(PULSE_LOW - 1);
    localparam logic [PH_W-1:0] TAIL_LAST  = PH_W'(TAIL_CYC - 1);
    localparam logic [PU_W-1:0] PULSE_LAST = PU_W'(NUM_PULSES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_HIGH  = 3'd2,
        S_LOW   = 3'd3,
        S_TAIL  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [PH_W-1:0] phase_q, phase_d;
    logic [PU_W-1:0] pulse_q, pulse_d;
    logic [35:0]     corner_q;
    logic [9:0]      maxiter_q;
    logic [8:0]      res_q;
    logic            write_q, busy_q, done_q;
    logic            capture_en;

    assign capture_en = (state_q == S_IDLE) && bus.start;

    always_comb begin
        state_d = state_q;
        phase_d = phase_q + 1'b1;
        pulse_d = pulse_q;
        case (state_q)
            S_IDLE: begin
                phase_d = '0;
                pulse_d = '0;
                if (bus.start) state_d = S_SETUP;
            end
            S_SETUP: begin
                pulse_d = '0;
                state_d = S_HIGH;
            end
            S_HIGH: begin
                if (phase_q == HIGH_LAST) begin
                    pulse_d = pulse_q + 1'b1;
                    state_d = (pulse_q == PULSE_LAST) ? S_TAIL : S_LOW;
                end
            end
            S_LOW: begin
                if (phase_q == LOW_LAST) state_d = S_HIGH;
            end
            S_TAIL: begin
                if (phase_q == TAIL_LAST) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Phase counter restarts on every state entry.
        if (state_d != state_q) phase_d = '0;
    end

    // Outputs are decoded from the next state and registered, so they line up with state_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            phase_q   <= '0;
            pulse_q   <= '0;
            write_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            corner_q  <= '0;
            maxiter_q <= '0;
            res_q     <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            pulse_q <= pulse_d;
            write_q <= (state_d == S_HIGH);
            busy_q  <= (state_d != S_IDLE);
            done_q  <= (state_d == S_DONE);
            if (capture_en) begin
                corner_q  <= bus.corner_in;
                maxiter_q <= bus.maxiter_in;
                res_q     <= bus.res_in;
            end
        end
    end

    assign bus.corner_d  = corner_q;
    assign bus.maxiter_d = maxiter_q;
    assign bus.res_d     = res_q;
    assign bus.write     = write_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_param_sender.sv
// Directed bench for param_sender: single transfer, receiver hand-off, ignored
// mid-transfer requests, back-to-back transfers and asynchronous reset mid-pulse.
module tb_param_sender;
    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    param_sender_if bus ();

    param_sender #(
        .PULSE_HIGH(2), .PULSE_LOW(2), .NUM_PULSES(5), .TAIL_CYC(3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Minimal receiver model: loads the bus on the 5th falling edge of write.
    int          rx_cnt;
    logic        wr_prev;
    logic        rx_new;
    logic [35:0] rx_corner;
    logic [9:0]  rx_maxiter;
    logic [8:0]  rx_res;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_cnt     <= 0;
            wr_prev    <= 1'b0;
            rx_new     <= 1'b0;
            rx_corner  <= '0;
            rx_maxiter <= '0;
            rx_res     <= '0;
        end else begin
            wr_prev <= bus.write;
            rx_new  <= 1'b0;
            if (wr_prev && !bus.write) begin
                if (rx_cnt == 4) begin
                    rx_cnt     <= 0;
                    rx_corner  <= bus.corner_d;
                    rx_maxiter <= bus.maxiter_d;
                    rx_res     <= bus.res_d;
                    rx_new     <= 1'b1;
                end else begin
                    rx_cnt <= rx_cnt + 1;
                end
            end
        end
    end

    // Per-cycle trace; index j is the sample taken after edge k+j, where edge k accepts start.
    logic        wr_tr [0:63];
    logic        dn_tr [0:63];
    logic        by_tr [0:63];
    logic        rx_tr [0:63];
    logic [35:0] cor_tr [0:63];
    logic [9:0]  mxi_tr [0:63];
    logic [8:0]  res_tr [0:63];
    logic [2:0]  st_tr [0:63];

    // Expected write level for a transfer whose start was accepted at trace index base.
    function automatic logic exp_wr(input int j, input int base);
        int t;
        t = j - base - 1;
        return (t >= 0) && (t < 18) && ((t % 4) < 2);
    endfunction

    task automatic run_xfer(input logic [35:0] c, input logic [9:0] m, input logic [8:0] r,
                            input int n, input int drop_at, input int mid_from, input int mid_to);
        @(negedge clk);
        bus.corner_in  = c;
        bus.maxiter_in = m;
        bus.res_in     = r;
        bus.start      = 1'b1;
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            if (j == drop_at) bus.start = 1'b0;
            if (j == mid_from) begin
                bus.start      = 1'b1;
                bus.corner_in  = 36'hF_FFFF_FFFF;
                bus.maxiter_in = 10'd7;
                bus.res_in     = 9'd5;
            end
            if (j == mid_to) bus.start = 1'b0;
            wr_tr[j]  = bus.write;
            dn_tr[j]  = bus.done;
            by_tr[j]  = bus.busy;
            rx_tr[j]  = rx_new;
            cor_tr[j] = bus.corner_d;
            mxi_tr[j] = bus.maxiter_d;
            res_tr[j] = bus.res_d;
            st_tr[j]  = bus.state_dbg;
        end
    endtask

    task automatic analyze(input int n, output int rises, output int done_first, output int done_cnt);
        rises      = 0;
        done_first = -1;
        done_cnt   = 0;
        for (int j = 0; j < n; j++) begin
            if (wr_tr[j] && (j == 0 || !wr_tr[j-1])) rises++;
            if (dn_tr[j]) begin
                done_cnt++;
                if (done_first < 0) done_first = j;
            end
        end
    endtask

    task automatic test_reset();
        int bad;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            tests_run++;
            if (bus.write !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
                bus.corner_d !== 36'd0 || bus.maxiter_d !== 10'd0 || bus.res_d !== 9'd0 ||
                bus.state_dbg !== 3'd0) begin
                tests_failed++;
                $display("FAIL reset_idle cycle %0d: write=%b busy=%b done=%b corner=%h maxiter=%0d res=%0d state=%0d, required all 0",
                         i, bus.write, bus.busy, bus.done, bus.corner_d, bus.maxiter_d, bus.res_d, bus.state_dbg);
            end
        end
    endtask

    task automatic test_single();
        int rises, dfirst, dcnt, bad_w, bad_b, bad_d;
        run_xfer(36'h0_ABCD_1234, 10'd500, 9'd320, 26, 0, -1, -1);
        analyze(26, rises, dfirst, dcnt);
        bad_w = 0; bad_b = 0; bad_d = 0;
        for (int j = 0; j < 26; j++) begin
            if (wr_tr[j] !== exp_wr(j, 0)) bad_w++;
            if (by_tr[j] !== (j <= 22)) bad_b++;
            if (cor_tr[j] !== 36'h0_ABCD_1234 || mxi_tr[j] !== 10'd500 || res_tr[j] !== 9'd320) bad_d++;
        end
        tests_run++;
        if (st_tr[0] !== 3'd1) begin tests_failed++; $display("FAIL single_setup_state: got %0d, required 1", st_tr[0]); end
        tests_run++;
        if (bad_w != 0) begin tests_failed++; $display("FAIL single_write_shape: %0d cycles wrong, required 0", bad_w); end
        tests_run++;
        if (rises != 5) begin tests_failed++; $display("FAIL single_pulse_count: got %0d, required 5", rises); end
        tests_run++;
        if (dfirst != 22) begin tests_failed++; $display("FAIL single_done_cycle: got k+%0d, required k+22", dfirst); end
        tests_run++;
        if (dcnt != 1) begin tests_failed++; $display("FAIL single_done_width: got %0d cycles, required 1", dcnt); end
        tests_run++;
        if (bad_b != 0) begin tests_failed++; $display("FAIL single_busy: %0d cycles wrong, required 0", bad_b); end
        tests_run++;
        if (bad_d != 0) begin tests_failed++; $display("FAIL single_bus_hold: %0d cycles wrong, required 0", bad_d); end
        tests_run++;
        if (st_tr[25] !== 3'd0) begin tests_failed++; $display("FAIL single_back_idle: state %0d, required 0", st_tr[25]); end
    endtask

    task automatic test_receiver();
        int rises, dfirst, dcnt, rx_first, rx_cnt_seen;
        run_xfer(36'h9_8765_4321, 10'd1023, 9'd1, 26, 0, -1, -1);
        analyze(26, rises, dfirst, dcnt);
        rx_first = -1; rx_cnt_seen = 0;
        for (int j = 0; j < 26; j++) begin
            if (rx_tr[j]) begin
                rx_cnt_seen++;
                if (rx_first < 0) rx_first = j;
            end
        end
        tests_run++;
        if (rx_corner !== 36'h9_8765_4321 || rx_maxiter !== 10'd1023 || rx_res !== 9'd1) begin
            tests_failed++;
            $display("FAIL rx_values: got %h/%0d/%0d, required 987654321/1023/1", rx_corner, rx_maxiter, rx_res);
        end
        tests_run++;
        if (rx_cnt_seen != 1 || rx_first < 0 || rx_first >= dfirst) begin
            tests_failed++;
            $display("FAIL rx_new_before_done: new_input count %0d at k+%0d, done k+%0d, required one pulse before done",
                     rx_cnt_seen, rx_first, dfirst);
        end
    endtask

    task automatic test_ignore_midxfer();
        int rises, dfirst, dcnt, bad_d;
        // Third HIGH phase occupies trace indices 9 and 10.
        run_xfer(36'h1_2345_6789, 10'd300, 9'd200, 26, 0, 9, 12);
        analyze(26, rises, dfirst, dcnt);
        bad_d = 0;
        for (int j = 0; j < 26; j++)
            if (cor_tr[j] !== 36'h1_2345_6789 || mxi_tr[j] !== 10'd300 || res_tr[j] !== 9'd200) bad_d++;
        tests_run++;
        if (bad_d != 0) begin tests_failed++; $display("FAIL ignore_bus_hold: %0d cycles wrong, required 0", bad_d); end
        tests_run++;
        if (rises != 5) begin tests_failed++; $display("FAIL ignore_pulse_count: got %0d, required 5", rises); end
        tests_run++;
        if (dfirst != 22 || dcnt != 1) begin
            tests_failed++;
            $display("FAIL ignore_done: first k+%0d count %0d, required k+22 count 1", dfirst, dcnt);
        end
        tests_run++;
        if (by_tr[23] !== 1'b0 || by_tr[25] !== 1'b0) begin
            tests_failed++;
            $display("FAIL ignore_no_queue: busy %b/%b after done, required 0/0", by_tr[23], by_tr[25]);
        end
    endtask

    task automatic test_back_to_back();
        int rises, dfirst, dcnt, bad_w, bad_b;
        run_xfer(36'h3_0000_000C, 10'd64, 9'd256, 48, 47, -1, -1);
        analyze(48, rises, dfirst, dcnt);
        bad_w = 0; bad_b = 0;
        for (int j = 0; j < 48; j++) begin
            if (wr_tr[j] !== (exp_wr(j, 0) | exp_wr(j, 24))) bad_w++;
            if (by_tr[j] !== (j != 23 && j != 47)) bad_b++;
        end
        tests_run++;
        if (rises != 10) begin tests_failed++; $display("FAIL b2b_pulse_count: got %0d, required 10", rises); end
        tests_run++;
        if (dcnt != 2 || dfirst != 22 || dn_tr[46] !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_done: count %0d first k+%0d second=%b, required 2 at k+22 and k+46", dcnt, dfirst, dn_tr[46]);
        end
        tests_run++;
        if (bad_w != 0) begin tests_failed++; $display("FAIL b2b_write_shape: %0d cycles wrong, required 0", bad_w); end
        tests_run++;
        if (bad_b != 0) begin tests_failed++; $display("FAIL b2b_idle_gap: %0d busy cycles wrong, required 0", bad_b); end
        tests_run++;
        if (st_tr[24] !== 3'd1) begin tests_failed++; $display("FAIL b2b_second_setup: state %0d, required 1", st_tr[24]); end
    endtask

    task automatic test_reset_midxfer();
        int rises, dfirst, dcnt, bad;
        @(negedge clk);
        bus.corner_in  = 36'hA_5A5A_5A5A;
        bus.maxiter_in = 10'd99;
        bus.res_in     = 9'd77;
        bus.start      = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        // Trace index 5 is the first cycle of the second HIGH phase.
        repeat (5) @(negedge clk);
        tests_run++;
        if (bus.write !== 1'b1) begin tests_failed++; $display("FAIL rstmid_pre_write: got %b, required 1", bus.write); end
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if (bus.write !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
            bus.corner_d !== 36'd0 || bus.maxiter_d !== 10'd0 || bus.res_d !== 9'd0) begin
            tests_failed++;
            $display("FAIL rstmid_async_clear: write=%b busy=%b done=%b corner=%h maxiter=%0d res=%0d, required all 0",
                     bus.write, bus.busy, bus.done, bus.corner_d, bus.maxiter_d, bus.res_d);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.write !== 1'b0 || bus.busy !== 1'b0) bad++;
        end
        tests_run++;
        if (bad != 0) begin tests_failed++; $display("FAIL rstmid_stays_idle: %0d cycles active, required 0", bad); end
        run_xfer(36'h0_0000_0001, 10'd2, 9'd3, 26, 0, -1, -1);
        analyze(26, rises, dfirst, dcnt);
        tests_run++;
        if (rises != 5 || dfirst != 22 || dcnt != 1 || cor_tr[25] !== 36'd1 || mxi_tr[25] !== 10'd2 || res_tr[25] !== 9'd3) begin
            tests_failed++;
            $display("FAIL rstmid_recovery: pulses %0d done k+%0d x%0d bus %h/%0d/%0d, required 5, k+22 x1, 1/2/3",
                     rises, dfirst, dcnt, cor_tr[25], mxi_tr[25], res_tr[25]);
        end
    endtask

    initial begin
        tests_run      = 0;
        tests_failed   = 0;
        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.corner_in  = '0;
        bus.maxiter_in = '0;
        bus.res_in     = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_single();
        test_receiver();
        test_ignore_midxfer();
        test_back_to_back();
        repeat (3) @(negedge clk);
        test_reset_midxfer();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "watchdog expired");
    end
endmodule
